phase_countdown: RTL and testbench
==================================

PHASE_COUNTDOWN -- requirements
Module: phase_countdown

Interface
REQ-001 Parameter NUM_PHASES, default 3: number of phases in the cycle, 2..8.
REQ-002 Parameter CNT_W, default 4: count width in bits.
REQ-003 Parameter STATE_W, default 2: phase index width, equal to clog2(NUM_PHASES) and minimum 1.
REQ-004 Parameter PHASE_INIT, default {4'd10,4'd5,4'd15}: packed NUM_PHASES*CNT_W reset reload values, phase 0 at LSBs.
REQ-005 clock_div  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  1 = run; 0 = hold state and count.
REQ-008 skip  input  1  force end of current phase this edge (honoured only when enable=1).
REQ-009 cfg_we  input  1  write strobe for the reload register.
REQ-010 cfg_phase  input  STATE_W  reload register index to write.
REQ-011 cfg_value  input  CNT_W  new reload value.
REQ-012 state  output  STATE_W  current phase index.
REQ-013 count  output  CNT_W  remaining count in the current phase.
REQ-014 phase_done  output  1  one-cycle registered pulse after any phase transition.
REQ-015 wrap  output  1  one-cycle registered pulse after a transition from phase NUM_PHASES-1 to phase 0.

Function
REQ-016 Edge with enable=1, skip=0 and count!=0 SHALL set count to count-1 and leave state unchanged.
REQ-017 Edge with enable=1 and either count==0 or skip=1 SHALL set state to next and count to reload[next]. next = state+1, or 0 when state==NUM_PHASES-1.
REQ-018 Phase p SHALL last reload[p]+1 enabled cycles absent skip. The defaults therefore give 16/6/11 cycles.
REQ-019 Reload value 0 SHALL produce a one-cycle phase; no phase is ever bypassed without being entered.
REQ-020 enable=0 SHALL freeze state and count; skip is ignored; phase_done and wrap SHALL be 0.
REQ-021 phase_done SHALL be 1 for exactly the cycle following each transition edge; wrap likewise, only for a NUM_PHASES-1 to 0 transition.
REQ-022 cfg_we=1 with cfg_phase<NUM_PHASES SHALL update reload[cfg_phase] at that edge, regardless of enable.
REQ-023 cfg_we=1 with cfg_phase>=NUM_PHASES SHALL be ignored.
REQ-024 When a config write and a load of the same phase coincide on one edge, the load SHALL use the old reload value; the new value applies from the next load.
REQ-025 A config write SHALL never alter the count of the phase in progress.
REQ-026 state SHALL never exceed NUM_PHASES-1; count arithmetic is modulo 2^CNT_W but never underflows, because 0 always triggers a load.

Reset
REQ-027 reset=0 SHALL immediately, without a clock, set state=0, count=PHASE_INIT[phase 0], phase_done=0, wrap=0.
REQ-028 reset=0 SHALL restore every reload register to its PHASE_INIT value.
REQ-029 Reset asserted mid-phase SHALL discard all progress.
REQ-030 The first edge after reset release with enable=1 SHALL decrement from PHASE_INIT[phase 0].

Structure
REQ-031 A shared package phase_pkg SHALL hold the default CNT_W, the default NUM_PHASES, the default PHASE_INIT constant and a clog2 helper function.
REQ-032 Sub-module phase_cfg_regs SHALL hold the reload register bank, including the write port and the reset-to-PHASE_INIT behaviour, exposing a combinational read by index.
REQ-033 The top level SHALL contain only the counter, the phase register and the pulse registers.

Verification
REQ-034 Defaults, enable=1 for 33 cycles after reset -> count 15..0 in phase 0, 5..0 in phase 1, 10..0 in phase 2, then state=0, count=15, wrap=1 for one cycle.
REQ-035 enable=0 for 4 cycles at state=1, count=3 -> outputs frozen at 1/3; decrement resumes to 2 after re-enable.
REQ-036 skip=1 at state=0, count=9 -> next cycle state=1, count=5, phase_done=1.
REQ-037 cfg write phase 1 := 2 on the same edge phase 1 loads -> count loads 5; the following cycle's phase 1 loads 2.
REQ-038 reset pulsed low between edges at state=2, count=4 -> state=0, count=15 asynchronously; any prior cfg writes are reverted.
REQ-039 NUM_PHASES=5, CNT_W=6, reload values all 0 -> state steps 0,1,2,3,4,0 on consecutive edges; phase_done held high; wrap on the 0 entry only; cfg_phase=7 write ignored.

Source files
------------

// File: rtl/phase_pkg.sv
// phase_pkg: shared defaults and width helper for the phase countdown sequencer.
package phase_pkg;

    localparam int DEF_NUM_PHASES = 3;
    localparam int DEF_CNT_W      = 4;
    localparam logic [DEF_NUM_PHASES*DEF_CNT_W-1:0] DEF_PHASE_INIT = {4'd10, 4'd5, 4'd15};

    // Index width for n phases, never below one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/phase_cfg_regs.sv
// phase_cfg_regs: per-phase reload register bank with a write port and a
// combinational read by index; resets to the PHASE_INIT values.
module phase_cfg_regs
    import phase_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int STATE_W    = clog2_min1(NUM_PHASES),
    parameter logic [NUM_PHASES*CNT_W-1:0] PHASE_INIT = DEF_PHASE_INIT
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               we_i,
    input  logic [STATE_W-1:0] wr_idx_i,
    input  logic [CNT_W-1:0]   wr_val_i,
    input  logic [STATE_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0]   rd_val_o
);

    logic [CNT_W-1:0] reload_q [NUM_PHASES];

    // Indices at or above NUM_PHASES match no slot, so such writes fall away.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int p = 0; p < NUM_PHASES; p++)
                reload_q[p] <= PHASE_INIT[p*CNT_W +: CNT_W];
        end else begin
            for (int p = 0; p < NUM_PHASES; p++)
                if (we_i && wr_idx_i == STATE_W'(p))
                    reload_q[p] <= wr_val_i;
        end
    end

    always_comb begin
        rd_val_o = '0;
        for (int p = 0; p < NUM_PHASES; p++)
            if (rd_idx_i == STATE_W'(p))
                rd_val_o = reload_q[p];
    end

endmodule

// File: rtl/phase_countdown.sv
// phase_countdown: cycles through NUM_PHASES phases, each lasting reload+1
// enabled cycles, with skip, live reload reconfiguration and transition pulses.
module phase_countdown
    import phase_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int STATE_W    = clog2_min1(NUM_PHASES),
    parameter logic [NUM_PHASES*CNT_W-1:0] PHASE_INIT = DEF_PHASE_INIT
) (
    input  logic               clock_div,
    input  logic               reset,
    input  logic               enable,
    input  logic               skip,
    input  logic               cfg_we,
    input  logic [STATE_W-1:0] cfg_phase,
    input  logic [CNT_W-1:0]   cfg_value,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   count,
    output logic               phase_done,
    output logic               wrap
);

    localparam logic [STATE_W-1:0] LAST = STATE_W'(NUM_PHASES - 1);

    logic [STATE_W-1:0] state_q, state_d, next_state;
    logic [CNT_W-1:0]   count_q, count_d, reload_val;
    logic               done_q, done_d, wrap_q, wrap_d, load;

    // The bank is read before this edge's write lands, so a coincident
    // write/load of one phase picks up the old value.
    phase_cfg_regs #(
        .NUM_PHASES(NUM_PHASES),
        .CNT_W     (CNT_W),
        .STATE_W   (STATE_W),
        .PHASE_INIT(PHASE_INIT)
    ) u_cfg (
        .clk_i   (clock_div),
        .rst_n_i (reset),
        .we_i    (cfg_we),
        .wr_idx_i(cfg_phase),
        .wr_val_i(cfg_value),
        .rd_idx_i(next_state),
        .rd_val_o(reload_val)
    );

    always_comb begin
        next_state = (state_q == LAST) ? '0 : state_q + 1'b1;
        load       = enable && (skip || count_q == '0);
        state_d    = load ? next_state : state_q;
        count_d    = load ? reload_val : (enable ? count_q - 1'b1 : count_q);
        done_d     = load;
        wrap_d     = load && (state_q == LAST);
    end

    always_ff @(posedge clock_div or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            count_q <= PHASE_INIT[CNT_W-1:0];
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign state      = state_q;
    assign count      = count_q;
    assign phase_done = done_q;
    assign wrap       = wrap_q;

    a_state_bound: assert property (@(posedge clock_div) disable iff (!reset) state_q <= LAST);

endmodule

// File: tb/tb_phase_countdown.sv
// tb_phase_countdown: random and directed stimulus against a phase-level
// reference model, plus a five-phase all-zero-reload instance.
module tb_phase_countdown;

    localparam int NP = 3;
    localparam int CW = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, en, skip, cfg_we;
    logic [SW-1:0] cfg_phase;
    logic [CW-1:0] cfg_value;
    wire  [SW-1:0] state;
    wire  [CW-1:0] count;
    wire           phase_done, wrap;

    logic          en5, we5;
    logic [2:0]    ph5;
    logic [5:0]    val5;
    wire  [2:0]    state5;
    wire  [5:0]    count5;
    wire           done5, wrap5;

    phase_countdown dut (
        .clock_div (clk),
        .reset     (rst_n),
        .enable    (en),
        .skip      (skip),
        .cfg_we    (cfg_we),
        .cfg_phase (cfg_phase),
        .cfg_value (cfg_value),
        .state     (state),
        .count     (count),
        .phase_done(phase_done),
        .wrap      (wrap)
    );

    phase_countdown #(.NUM_PHASES(5), .CNT_W(6), .STATE_W(3), .PHASE_INIT(30'd0)) dut5 (
        .clock_div (clk),
        .reset     (rst_n),
        .enable    (en5),
        .skip      (1'b0),
        .cfg_we    (we5),
        .cfg_phase (ph5),
        .cfg_value (val5),
        .state     (state5),
        .count     (count5),
        .phase_done(done5),
        .wrap      (wrap5)
    );

    int checks = 0;
    int errors = 0;

    int m_reload [NP];
    int m_state, m_count;
    bit m_done, m_wrap;
    int init_vals [NP] = '{15, 5, 10};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_reload = init_vals;
        m_state  = 0;
        m_count  = init_vals[0];
        m_done   = 0;
        m_wrap   = 0;
    endtask

    // One enabled edge either counts down or enters the following phase
    // with the reload value that held before any same-edge write.
    task automatic model_edge();
        int old_reload [NP];
        int nxt;
        old_reload = m_reload;
        if (cfg_we && int'(cfg_phase) < NP) m_reload[cfg_phase] = int'(cfg_value);
        m_done = 0;
        m_wrap = 0;
        if (en) begin
            if (skip || m_count == 0) begin
                nxt     = (m_state + 1) % NP;
                m_done  = 1;
                m_wrap  = (nxt == 0);
                m_state = nxt;
                m_count = old_reload[nxt];
            end else begin
                m_count = m_count - 1;
            end
        end
    endtask

    task automatic compare();
        chk("state", 32'(state), 32'(m_state));
        chk("count", 32'(count), 32'(m_count));
        chk("phase_done", 32'(phase_done), 32'(m_done));
        chk("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare();
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_count", 32'(count), 32'd15);
        @(negedge clk);
        compare();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 0; skip = 0; cfg_we = 0; cfg_phase = '0; cfg_value = '0;
        en5 = 0; we5 = 0; ph5 = '0; val5 = '0;
        model_reset();
        #12;
        compare();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_count", 32'(count), 32'd15);
        chk("reset_state5", 32'(state5), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full default cycle: 16 + 6 + 11 enabled cycles.
        en = 1;
        for (int i = 1; i <= 33; i++) begin
            tick();
            if (i == 1)  chk("first_decrement", 32'(count), 32'd14);
            if (i == 16) chk("enter_p1_count", 32'(count), 32'd5);
            if (i == 22) chk("enter_p2_count", 32'(count), 32'd10);
        end
        chk("wrap_state", 32'(state), 32'd0);
        chk("wrap_count", 32'(count), 32'd15);
        chk("wrap_pulse", 32'(wrap), 32'd1);
        tick();
        chk("wrap_cleared", 32'(wrap), 32'd0);

        // Freeze at phase 1, count 3; skip must be ignored while disabled.
        for (int i = 0; i < 17; i++) tick();
        chk("pre_freeze_state", 32'(state), 32'd1);
        chk("pre_freeze_count", 32'(count), 32'd3);
        en = 0; skip = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("frozen_count", 32'(count), 32'd3);
        chk("frozen_done", 32'(phase_done), 32'd0);
        en = 1; skip = 0;
        tick();
        chk("resume_count", 32'(count), 32'd2);

        // Skip from phase 0 at count 9.
        for (int i = 0; i < 100 && !(m_state == 0 && m_count == 9); i++) tick();
        chk("pre_skip_count", 32'(count), 32'd9);
        skip = 1;
        tick();
        skip = 0;
        chk("skip_state", 32'(state), 32'd1);
        chk("skip_count", 32'(count), 32'd5);
        chk("skip_done", 32'(phase_done), 32'd1);

        // Config write colliding with the load of the same phase.
        for (int i = 0; i < 100 && !(m_state == 0 && m_count == 0); i++) tick();
        cfg_we = 1; cfg_phase = 2'd1; cfg_value = 4'd2;
        tick();
        cfg_we = 0;
        chk("collide_old_value", 32'(count), 32'd5);
        tick();
        for (int i = 0; i < 100 && !(m_state == 1 && m_done); i++) tick();
        chk("new_value_next_load", 32'(count), 32'd2);

        // Asynchronous reset mid-phase reverts the written reload value.
        for (int i = 0; i < 100 && !(m_state == 2 && m_count == 4); i++) tick();
        do_reset();
        for (int i = 0; i < 100 && !(m_state == 1 && m_done); i++) tick();
        chk("reload_reverted", 32'(count), 32'd5);

        // Randomised traffic, including out-of-range writes and resets.
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 3) != 0);
            skip      = ($urandom_range(0, 6) == 0);
            cfg_we    = ($urandom_range(0, 4) == 0);
            cfg_phase = 2'($urandom_range(0, 3));
            cfg_value = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) do_reset();
            else tick();
        end
        en = 0; skip = 0; cfg_we = 0;

        // Five phases, all reloads zero: one phase per edge.
        en5 = 1; we5 = 1; ph5 = 3'd7; val5 = 6'd9;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("p5_state", 32'(state5), 32'(i % 5));
            chk("p5_count", 32'(count5), 32'd0);
            chk("p5_done", 32'(done5), 32'd1);
            chk("p5_wrap", 32'(wrap5), 32'((i % 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
